// File: rtl/adc_result_reader_pkg.sv
// ----------------------------------------------------------------------------
// adc_result_reader_pkg
//
// Shared constants and helpers for the ADC result reader.
//   DEFAULT_MATRIX_BITS : result width produced by the SAR ADC controller
//   DEFAULT_FIFO_DEPTH  : number of buffered results (power of two, >= 2)
//   clog2()             : pointer-width helper
//   fill_width()        : width of a fill-level count able to hold 0..depth
// ----------------------------------------------------------------------------
package adc_result_reader_pkg;

  localparam int DEFAULT_MATRIX_BITS = 12;
  localparam int DEFAULT_FIFO_DEPTH  = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // The count has to reach depth itself, hence one bit more than the pointer.
  function automatic int fill_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_FILL_W = fill_width(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/adc_result_reader_if.sv
// ----------------------------------------------------------------------------
// adc_result_reader_if
//
// Result stream from the reader to the digital back-end.
//   data_out       : FIFO head, 0 when empty
//   data_valid_out : FIFO holds at least one result
//   data_ready_in  : consumer takes data_out this cycle
//
// Handshake: a transfer happens on every rising clock edge where
// data_valid_out and data_ready_in are both 1. The producer never makes
// data_valid_out or data_out depend combinationally on data_ready_in; once
// valid is high the head stays put until it is transferred (or flushed by a
// clear or reset). The consumer may raise or drop ready freely.
//
// Modports: master = reader side, slave = back-end side.
// ----------------------------------------------------------------------------
interface adc_result_reader_if
  import adc_result_reader_pkg::*;
#(
  parameter int MATRIX_BITS = DEFAULT_MATRIX_BITS
);

  logic [MATRIX_BITS-1:0] data_out;
  logic                   data_valid_out;
  logic                   data_ready_in;

  modport master (
    output data_out,
    output data_valid_out,
    input  data_ready_in
  );

  modport slave (
    input  data_out,
    input  data_valid_out,
    output data_ready_in
  );

endinterface

// File: rtl/adc_result_fifo.sv
// ----------------------------------------------------------------------------
// adc_result_fifo
//
// Small synchronous FIFO for ADC results. Separate read/write pointers that
// wrap naturally plus an explicit count, so full and empty are unambiguous.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   push_in          : write data_in this cycle
//   pop_in           : drop the head this cycle (ignored when empty)
//   clear_in         : flush; beats any same-cycle push/pop
//   overwrite_en_in  : push while full without pop replaces the oldest entry
//                      instead of being dropped
//   data_in          : value to write
//   head_out         : oldest entry, 0 when empty
//   not_empty_out    : at least one entry stored
//   full_out         : DEPTH entries stored
//   count_out        : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module adc_result_fifo
  import adc_result_reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_MATRIX_BITS,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_in,
  input  logic                         pop_in,
  input  logic                         clear_in,
  input  logic                         overwrite_en_in,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             head_out,
  output logic                         not_empty_out,
  output logic                         full_out,
  output logic [fill_width(DEPTH)-1:0] count_out
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = fill_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_in && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same
    // cycle, or when overwriting is enabled.
    do_push  = push_in && (!full || do_pop || overwrite_en_in);

    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      // Overwrite: the oldest entry is sacrificed by stepping the read
      // pointer past it, since the write lands on that very slot.
      if (do_pop || (do_push && full)) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (do_push && !do_pop && !full) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Decoded from registers only; stale storage never leaks out when empty.
  assign head_out      = empty ? '0 : mem_q[rd_ptr_q];
  assign not_empty_out = !empty;
  assign full_out      = full;
  assign count_out     = count_q;

endmodule

// File: rtl/adc_result_reader.sv
// ----------------------------------------------------------------------------
// adc_result_reader
//
// Captures each completed result of the SAR ADC controller on the rising edge
// of its conversion-finished strobe and buffers it in a FIFO that drains
// through a valid/ready stream. The very first capture after reset is the
// controller's reset result and is discarded. A capture that finds the FIFO
// full (with no same-cycle pop) sets a sticky overflow flag.
//
// Configuration macro: ADC_READER_OVERWRITE_EN
//   defined   : push into a full FIFO overwrites the oldest entry
//   undefined : push into a full FIFO is dropped (default)
//
// Ports:
//   clk              : system clock, shared with the ADC controller
//   nrst             : asynchronous active-low reset
//   conv_finished_in : conversion-finished strobe from the controller
//   result_in        : ADC result, stable while conv_finished_in is high
//   clear_in         : synchronous flush of FIFO and overflow flag
//   bus              : result stream (data_out / data_valid_out / data_ready_in)
//   fill_level_out   : number of stored results, 0..FIFO_DEPTH
//   overflow_out     : sticky, a capture arrived while the FIFO was full
// ----------------------------------------------------------------------------
module adc_result_reader
  import adc_result_reader_pkg::*;
#(
  parameter int MATRIX_BITS = DEFAULT_MATRIX_BITS,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              conv_finished_in,
  input  logic [MATRIX_BITS-1:0]            result_in,
  input  logic                              clear_in,
  adc_result_reader_if.master               bus,
  output logic [fill_width(FIFO_DEPTH)-1:0] fill_level_out,
  output logic                              overflow_out
);

`ifdef ADC_READER_OVERWRITE_EN
  localparam logic OVERWRITE_EN = 1'b1;
`else
  localparam logic OVERWRITE_EN = 1'b0;
`endif

  logic conv_finished_q, conv_finished_d;
  logic armed_q,         armed_d;
  logic overflow_q,      overflow_d;

  logic                   capture;
  logic                   push;
  logic                   pop;
  logic                   fifo_not_empty;
  logic                   fifo_full;
  logic [MATRIX_BITS-1:0] fifo_head;

  always_comb begin
    conv_finished_d = conv_finished_in;
    capture         = conv_finished_in && !conv_finished_q;
    // The first capture only arms the reader; clear_in leaves armed alone.
    armed_d         = armed_q || capture;
    push            = capture && armed_q;
    pop             = fifo_not_empty && bus.data_ready_in;

    overflow_d = overflow_q;
    if (clear_in) begin
      overflow_d = 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      conv_finished_q <= 1'b0;
      armed_q         <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      conv_finished_q <= conv_finished_d;
      armed_q         <= armed_d;
      overflow_q      <= overflow_d;
    end
  end

  adc_result_fifo #(
    .WIDTH (MATRIX_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk             (clk),
    .rst_n           (nrst),
    .push_in         (push),
    .pop_in          (pop),
    .clear_in        (clear_in),
    .overwrite_en_in (OVERWRITE_EN),
    .data_in         (result_in),
    .head_out        (fifo_head),
    .not_empty_out   (fifo_not_empty),
    .full_out        (fifo_full),
    .count_out       (fill_level_out)
  );

  assign bus.data_out       = fifo_head;
  assign bus.data_valid_out = fifo_not_empty;
  assign overflow_out       = overflow_q;

endmodule

// File: tb/tb_adc_result_reader.sv
// ----------------------------------------------------------------------------
// tb_adc_result_reader
//
// Directed bench for adc_result_reader: a table of single-cycle vectors for
// discard, push/pop and clear behaviour, then hand-written sequences for
// ordering/wrap, overflow, full push+pop and mid-stream reset.
// Honours ADC_READER_OVERWRITE_EN for the overflow expectations.
// ----------------------------------------------------------------------------
module tb_adc_result_reader;

  localparam int W = 12;

  logic         clk;
  logic         nrst;
  logic         conv_finished_in;
  logic [W-1:0] result_in;
  logic         clear_in;
  logic [2:0]   fill_level_out;
  logic         overflow_out;

  adc_result_reader_if #(.MATRIX_BITS(W)) bus ();

  adc_result_reader #(
    .MATRIX_BITS (W),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .conv_finished_in (conv_finished_in),
    .result_in        (result_in),
    .clear_in         (clear_in),
    .bus              (bus),
    .fill_level_out   (fill_level_out),
    .overflow_out     (overflow_out)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int tests_run;
  int tests_failed;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic valid, input logic [W-1:0] data,
                               input logic [2:0] fill, input logic ovf);
    check({name, " valid"},    32'(bus.data_valid_out), 32'(valid));
    check({name, " data"},     32'(bus.data_out),       32'(data));
    check({name, " fill"},     32'(fill_level_out),     32'(fill));
    check({name, " overflow"}, 32'(overflow_out),       32'(ovf));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] value);
    conv_finished_in = 1'b1;
    result_in        = value;
    step();
    conv_finished_in = 1'b0;
    step();
  endtask

  task automatic drain(input string name, input int n);
    logic [W-1:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = exp_q.pop_front();
      check({name, " drain valid"}, 32'(bus.data_valid_out), 32'd1);
      check({name, " drain data"},  32'(bus.data_out),       32'(exp));
      bus.data_ready_in = 1'b1;
      step();
      bus.data_ready_in = 1'b0;
    end
    check({name, " empty valid"}, 32'(bus.data_valid_out), 32'd0);
    check({name, " empty data"},  32'(bus.data_out),       32'd0);
    check({name, " empty fill"},  32'(fill_level_out),     32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         conv;
    logic [W-1:0] result;
    logic         clear;
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_fill;
    logic         exp_ovf;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //            conv  result   clr   rdy   valid data     fill  ovf
    vecs[0]  = '{1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0}; // startup discard
    vecs[1]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 12'h5A3, 1'b0, 1'b0, 1'b1, 12'h5A3, 3'd1, 1'b0}; // first real capture
    vecs[3]  = '{1'b0, 12'h5A3, 1'b0, 1'b0, 1'b1, 12'h5A3, 3'd1, 1'b0};
    vecs[4]  = '{1'b1, 12'h123, 1'b0, 1'b0, 1'b1, 12'h5A3, 3'd2, 1'b0};
    vecs[5]  = '{1'b0, 12'h123, 1'b0, 1'b1, 1'b1, 12'h123, 3'd1, 1'b0}; // pop
    vecs[6]  = '{1'b1, 12'h456, 1'b0, 1'b1, 1'b1, 12'h456, 3'd1, 1'b0}; // push + pop
    vecs[7]  = '{1'b0, 12'h456, 1'b0, 1'b1, 1'b0, 12'h000, 3'd0, 1'b0}; // pop to empty
    vecs[8]  = '{1'b0, 12'h456, 1'b0, 1'b1, 1'b0, 12'h000, 3'd0, 1'b0}; // pop while empty
    vecs[9]  = '{1'b1, 12'h777, 1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0}; // clear beats push
    vecs[10] = '{1'b0, 12'h777, 1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0};
    vecs[11] = '{1'b1, 12'h0BC, 1'b0, 1'b0, 1'b1, 12'h0BC, 3'd1, 1'b0}; // no discard after clear
    vecs[12] = '{1'b0, 12'h0BC, 1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0}; // clear

    // ---------------- reset ----------------
    nrst              = 1'b0;
    conv_finished_in  = 1'b0;
    result_in         = '0;
    clear_in          = 1'b0;
    bus.data_ready_in = 1'b0;
    #1;
    check_outputs("reset", 1'b0, 12'h000, 3'd0, 1'b0);
    step();
    step();
    nrst = 1'b1;
    step();

    // ---------------- table ----------------
    for (int i = 0; i < NVEC; i++) begin
      conv_finished_in  = vecs[i].conv;
      result_in         = vecs[i].result;
      clear_in          = vecs[i].clear;
      bus.data_ready_in = vecs[i].ready;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                    vecs[i].exp_fill, vecs[i].exp_ovf);
    end
    conv_finished_in  = 1'b0;
    clear_in          = 1'b0;
    bus.data_ready_in = 1'b0;
    step();

    // ---------------- ordering and pointer wrap ----------------
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 1; k <= 4; k++) begin
        pulse(W'(k));
        exp_q.push_back(W'(k));
      end
      check($sformatf("wrap%0d fill", rep), 32'(fill_level_out), 32'd4);
      drain($sformatf("wrap%0d", rep), 4);
    end

    // ---------------- overflow ----------------
    for (int k = 'h11; k <= 'h14; k++) begin
      pulse(W'(k));
    end
    pulse(12'h015);
    check("ovf fill", 32'(fill_level_out), 32'd4);
    check("ovf flag", 32'(overflow_out),   32'd1);
`ifdef ADC_READER_OVERWRITE_EN
    for (int k = 'h12; k <= 'h15; k++) exp_q.push_back(W'(k));
`else
    for (int k = 'h11; k <= 'h14; k++) exp_q.push_back(W'(k));
`endif
    drain("ovf", 4);
    check("ovf sticky", 32'(overflow_out), 32'd1);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    check("ovf cleared", 32'(overflow_out), 32'd0);

    // ---------------- full with simultaneous push and pop ----------------
    for (int k = 'h21; k <= 'h24; k++) begin
      pulse(W'(k));
      exp_q.push_back(W'(k));
    end
    check("fullpp fill before", 32'(fill_level_out), 32'd4);
    check("fullpp head before", 32'(bus.data_out),   32'h021);
    conv_finished_in  = 1'b1;
    result_in         = 12'h0AA;
    bus.data_ready_in = 1'b1;
    step();
    conv_finished_in  = 1'b0;
    bus.data_ready_in = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(12'h0AA);
    check("fullpp fill after", 32'(fill_level_out), 32'd4);
    check("fullpp overflow",   32'(overflow_out),   32'd0);
    step();
    drain("fullpp", 4);

    // ---------------- reset mid-stream ----------------
    pulse(12'h201);
    pulse(12'h202);
    check("midrst fill before", 32'(fill_level_out), 32'd2);
    nrst = 1'b0;
    #1;
    check_outputs("midrst async", 1'b0, 12'h000, 3'd0, 1'b0);
    step();
    nrst = 1'b1;
    step();
    pulse(12'h300);
    check_outputs("midrst discard", 1'b0, 12'h000, 3'd0, 1'b0);
    pulse(12'h301);
    check_outputs("midrst capture", 1'b1, 12'h301, 3'd1, 1'b0);
    exp_q.push_back(12'h301);
    drain("midrst", 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
